// File: rtl/instr_fetch.sv
// Beta fetch stage: issues word-aligned fetches to instruction memory, buffers
// in-order responses in a prefetch FIFO and hands them to decode; redirects
// flush the FIFO and discard responses still in flight.
// Optional build macro: INSTR_FETCH_ILLEGAL_CHECK_EN (per-entry illegal-opcode flag).
module instr_fetch #(
  parameter int unsigned           ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus4,
  output logic              out_illegal
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] WORD_MASK        = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = RESET_PC & WORD_MASK;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              req_valid_q, req_valid_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  stale_q, stale_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W:0]    inflight;

  logic [31:0]       instr_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [FIFO_DEPTH];

  logic req_fire;
  logic push;
  logic pop;

  assign req_fire = req_valid_q & imem_req_ready;
  assign out_valid = (count_q != '0);
  assign pop  = out_valid & out_ready;
  // A response is kept only if nothing older is stale and no redirect is flushing this cycle.
  assign push = imem_rsp_valid & (stale_q == '0) & ~redirect_valid;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    outst_d     = outst_q;
    stale_d     = stale_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    req_valid_d = req_valid_q;
    inflight    = '0;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end

    unique case ({req_fire, imem_rsp_valid})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (imem_rsp_valid && (stale_q != '0)) begin
      stale_d = stale_q - CNT_W'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      rsp_pc_d = rsp_pc_q + ADDR_W'(4);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      ST_DRAIN: if (stale_d == '0) state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase

    // Redirect wins over everything above; whatever is still outstanding after
    // this cycle's accept/response becomes stale.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & WORD_MASK;
      rsp_pc_d   = redirect_pc & WORD_MASK;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      stale_d    = outst_d;
      if (state_q == ST_DRAIN || outst_d != '0) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_RUN;
      end
    end

    inflight = {1'b0, outst_d} + {1'b0, count_d};
    if (redirect_valid) begin
      req_valid_d = 1'b0;
    end else if (req_valid_q && !imem_req_ready) begin
      req_valid_d = 1'b1;
    end else begin
      req_valid_d = (state_d == ST_RUN) && (inflight < (CNT_W + 1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      fetch_pc_q  <= RESET_PC_ALIGNED;
      rsp_pc_q    <= RESET_PC_ALIGNED;
      req_valid_q <= 1'b0;
      outst_q     <= '0;
      stale_q     <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      req_valid_q <= req_valid_d;
      outst_q     <= outst_d;
      stale_q     <= stale_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; an entry is only read after count_q says it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
  logic ill_mem_q [FIFO_DEPTH];

  // Legal opcodes: 0x18-0x1F, then 0x20-0x3F except the ...111 slot of each group of eight.
  function automatic logic is_illegal(input logic [5:0] opcode);
    logic legal;
    legal = (opcode[5:3] == 3'd3) || (opcode[5] && (opcode[2:0] != 3'b111));
    return ~legal;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      ill_mem_q[wr_ptr_q] <= is_illegal(imem_rsp_data[31:26]);
    end
  end

  assign out_illegal = out_valid & ill_mem_q[rd_ptr_q];
`else
  assign out_illegal = 1'b0;
`endif

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign out_instr      = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_pc         = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign out_pc_plus4   = out_valid ? (pc_mem_q[rd_ptr_q] + ADDR_W'(4)) : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-programmable memory model plus
// request/response scoreboards filled by the stimulus and drained by monitors.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_illegal;

  instr_fetch #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0000_0102),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_illegal    (out_illegal)
  );

  always #5 clk = ~clk;

`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t        exp_out [$];
  logic [31:0] exp_req [$];
  pend_t       pend    [$];
  exp_t        mon_e;
  int          grants = 0;
  int          lat    = 1;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h9C00_0000;
    if (a == 32'h0000_3004) return 32'h8000_0000;
    return {6'h18, a[25:0]};
  endfunction

  function automatic logic exp_ill(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return ILL_EN && !(op inside {[6'h18:6'h1F], [6'h20:6'h26], [6'h28:6'h2E],
                                  [6'h30:6'h36], [6'h38:6'h3E]});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One granted fetch at pc; deliver=0 means the response must be discarded.
  task automatic expect_fetch(input logic [31:0] pc, input bit deliver);
    exp_t e;
    exp_req.push_back(pc);
    if (deliver) begin
      e.pc    = pc;
      e.instr = mem_word(pc);
      e.ill   = exp_ill(mem_word(pc));
      exp_out.push_back(e);
    end
    grants++;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && (exp_out.size() != 0 || exp_req.size() != 0 || pend.size() != 0); i++)
      tick();
    check(tag, exp_out.size() + exp_req.size(), 0);
  endtask

  // Memory model: in-order responses, lat cycles after acceptance, one per cycle.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        check("req_expected", exp_req.size() != 0, 1);
        if (exp_req.size() != 0) check("req_addr", imem_req_addr, exp_req.pop_front());
        pend.push_back('{imem_req_addr, cyc + 1 + lat});
        grants--;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
      end else if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      imem_req_ready = (grants > 0);
    end
  end

  // Output monitor: every decode handshake must match the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        check("out_expected", exp_out.size() != 0, 1);
        if (exp_out.size() != 0) begin
          mon_e = exp_out.pop_front();
          check("out_pc", out_pc, mon_e.pc);
          check("out_instr", out_instr, mon_e.instr);
          check("out_pc_plus4", out_pc_plus4, mon_e.pc + 32'd4);
          check("out_illegal", out_illegal, mon_e.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    lat            = 1;

    // Reset state and boot from RESET_PC with low bits masked.
    expect_fetch(32'h100, 1);
    expect_fetch(32'h104, 1);
    expect_fetch(32'h108, 1);
    expect_fetch(32'h10C, 1);
    repeat (3) tick();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_pc_plus4", out_pc_plus4, 0);
    check("rst_out_illegal", out_illegal, 0);
    rst_n = 1'b1;
    tick();
    check("boot_req_valid", imem_req_valid, 1);
    check("boot_req_addr", imem_req_addr, 32'h100);
    check("boot_out_valid_c1", out_valid, 0);
    tick();
    check("boot_out_valid_c2", out_valid, 0);
    tick();
    check("boot_out_valid_c3", out_valid, 1);
    wait_drain("t1_drain");

    // Decode stalled, 2-cycle memory: credit limits fetch to two requests.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    lat            = 2;
    expect_fetch(32'h0, 1);
    expect_fetch(32'h4, 1);
    expect_fetch(32'h8, 1);
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    check("t2_grants_left", grants, 1);
    check("t2_req_blocked", imem_req_valid, 0);
    check("t2_head_valid", out_valid, 1);
    check("t2_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    check("t2_second_valid", out_valid, 1);
    check("t2_second_pc", out_pc, 32'h4);
    wait_drain("t2_drain");

    // Two requests in flight, then redirect to an unaligned target.
    lat = 6;
    expect_fetch(32'hC, 0);
    expect_fetch(32'h10, 0);
    for (int i = 0; i < 20 && grants != 0; i++) tick();
    check("t3_both_accepted", grants, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2002;
    tick();
    redirect_valid = 1'b0;
    check("t3_post_redir_out", out_valid, 0);
    check("t3_post_redir_req", imem_req_valid, 0);
    for (int i = 0; i < 20 && pend.size() != 0; i++) begin
      check("t3_drain_noreq", imem_req_valid, 0);
      tick();
    end
    expect_fetch(32'h2000, 1);
    wait_drain("t3_drain");

    // Redirect coincident with a response and a decode handshake.
    lat       = 3;
    out_ready = 1'b0;
    expect_fetch(32'h2004, 1);
    expect_fetch(32'h2008, 0);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("t4_head_valid", out_valid, 1);
    check("t4_head_pc", out_pc, 32'h2004);
    check("t4_rsp_same_cycle", imem_rsp_valid, 1);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    lat            = 1;
    tick();
    redirect_valid = 1'b0;
    check("t4_post_redir_out", out_valid, 0);
    check("t4_post_redir_req", imem_req_valid, 0);
    expect_fetch(32'h3000, 1);
    expect_fetch(32'h3004, 1);
    wait_drain("t4_drain");

    // Fetch address wraps at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    expect_fetch(32'hFFFF_FFFC, 1);
    expect_fetch(32'h0000_0000, 1);
    wait_drain("t5_drain");

    check("final_req_queue", exp_req.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the Beta pipeline, directly upstream of instruction decode.
- Generates word-aligned fetch addresses, issues them to instruction memory over a valid/ready request channel, and buffers in-order responses in a small prefetch FIFO.
- Presents 32-bit instruction words in the team's opcode/Rc/Ra/Rb|lit layout (opcode = bits [31:26]) to decode over a valid/ready handshake.
- Handles PC redirects from branch/JMP resolution by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- ADDR_W, 32: width of the PC and memory address.
- RESET_PC, 0: PC value after reset; bits [1:0] are ignored.
- FIFO_DEPTH, 2: prefetch FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  ADDR_W  fetch address; bits [1:0] always 0.
- imem_rsp_valid  in  1  response valid; in order, at most 1 per cycle, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  load new PC (taken branch or JMP).
- redirect_pc  in  ADDR_W  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts.
- out_instr  out  32  instruction word.
- out_pc  out  ADDR_W  address of out_instr.
- out_pc_plus4  out  ADDR_W  out_pc + 4, modulo 2^ADDR_W.
- out_illegal  out  1  opcode not in the legal set (see Optional Feature).

Behaviour:
- Reset (async, active-low): state = BOOT, fetch_pc = RESET_PC & ~3, FIFO empty, outstanding = 0, stale = 0, imem_req_valid = 0, out_valid = 0, out_instr = 0, out_pc = 0, out_pc_plus4 = 0, out_illegal = 0. Reset mid-transaction abandons all in-flight requests; responses arriving after reset release must not occur (memory shares the reset).
- FSM:
  - BOOT: one idle cycle, then -> RUN.
  - RUN: normal fetch.
  - DRAIN: waiting for stale responses.
- Issue rule in RUN: imem_req_valid = 1 iff outstanding + fifo_count < FIFO_DEPTH and no redirect this cycle. Request valid and address are registered; once asserted they are held stable until accepted, except on redirect.
- On request acceptance, fetch_pc += 4 with wrap at 2^ADDR_W, and outstanding++.
- Response handling:
  - Any response decrements outstanding.
  - If stale > 0, the response is dropped and stale-- .
  - Otherwise it is pushed to the FIFO with its PC (a per-entry PC FIFO or response-PC counter).
- Output: the FIFO head drives out_* combinationally. The entry pops on out_valid & out_ready. Zero-latency bypass from response to output is not provided; minimum latency from request acceptance to out_valid is 2 cycles.
- Simultaneous push and pop on a full FIFO is legal. The credit rule guarantees no overflow.
- Redirect (any state):
  - fetch_pc = redirect_pc & ~3; FIFO flushed.
  - stale = outstanding after this cycle's accept/response updates. A request accepted in the redirect cycle counts as stale; a response arriving in the redirect cycle is dropped.
  - imem_req_valid deasserts the next cycle.
  - Next state = DRAIN if the new stale > 0, else RUN.
- Redirect coincident with an out handshake: the handshake completes (decode owns that instruction) and the remaining entries are flushed.
- DRAIN: no new requests. -> RUN when stale reaches 0. A redirect in DRAIN updates fetch_pc and stays in DRAIN.
- out_valid is 0 whenever the FIFO is empty, and in the cycle after a redirect.

Optional Feature:
- Macro: INSTR_FETCH_ILLEGAL_CHECK_EN.
- Defined: out_illegal = 1 when out_valid and opcode [31:26] is not in the legal set 0x18–0x1F, 0x20–0x26, 0x28–0x2E, 0x30–0x36, 0x38–0x3E. The flag travels with its FIFO entry, computed at push.
- Undefined: out_illegal is tied to 0 and no per-entry flag storage is built.

Test Plan:
- Reset, RESET_PC = 0x100, memory 1-cycle latency, out_ready = 1 -> requests at 0x100, 0x104, 0x108…; out_pc sequence matches, out_pc_plus4 = out_pc + 4, first out_valid 3 cycles after rst_n rises.
- out_ready = 0 with 2-cycle memory latency -> exactly 2 requests issued, FIFO holds 0x0 and 0x4; out_ready = 1 then drains in order, 1 per cycle.
- 2 requests outstanding, redirect_pc = 0x2002 -> both responses dropped, state DRAIN, then first request at 0x2000, out_pc = 0x2000.
- Redirect in the same cycle as a response and an out handshake -> handshaken instruction delivered once, response dropped, no stale output appears.
- fetch_pc = 0xFFFFFFFC -> next request address 0x00000000, out_pc_plus4 = 0x0.
- With INSTR_FETCH_ILLEGAL_CHECK_EN, word 0x9C000000 (opcode 0x27) -> out_illegal = 1; 0x80000000 (ADD) -> 0; without the macro, both -> 0.
